xmit_mac_ctrl: RTL



---
 rtl/wimpfi_pkg.sv | 30 +++
 rtl/lfsr8.sv | 35 +++
 rtl/xmit_mac_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/wimpfi_pkg.sv
// Shared types and constants for the WIMPFI transmit MAC.
// Holds the controller state encoding, framing bytes and LFSR/contention-window helpers.
package wimpfi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DIFS     = 3'd1,
        ST_BACKOFF  = 3'd2,
        ST_PREAMBLE = 3'd3,
        ST_SFD      = 3'd4,
        ST_DATA     = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD0;
    localparam logic [7:0] LFSR_SEED     = 8'hA5;
    localparam logic [2:0] CW_EXP_MIN    = 3'd2;
    localparam logic [2:0] CW_EXP_MAX    = 3'd7;

    // Fibonacci step for x^8+x^6+x^5+x^4+1, shifting toward the MSB.
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
    endfunction

    function automatic logic [7:0] cw_mask_of(input logic [2:0] cw_exp);
        return (8'd1 << cw_exp) - 8'd1;
    endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit pseudo-random source used to draw the backoff value.
// Advances every clock; a zero state is steered back to the seed so it can never lock up.
module lfsr8
    import wimpfi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] value
);

    logic [7:0] lfsr_r;
    logic [7:0] step_s;

    // Next LFSR value with lock-up protection.
    always_comb begin
        step_s = lfsr_next(lfsr_r);
        if (step_s == 8'h00) begin
            step_s = LFSR_SEED;
        end else begin
            step_s = step_s;
        end
    end

    // LFSR state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= step_s;
        end
    end

    assign value = lfsr_r;

endmodule

// File: rtl/xmit_mac_ctrl.sv
// CSMA transmit controller: DIFS wait, random backoff with carrier deferral, then
// preamble, SFD and FIFO payload handed byte-by-byte to the Manchester transmitter.
module xmit_mac_ctrl
    import wimpfi_pkg::*;
#(
    parameter int unsigned DIFS_TICKS     = 40,
    parameter int unsigned SLOT_TICKS     = 8,
    parameter int unsigned PREAMBLE_BYTES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mx_br_en,
    input  logic       cardet,
    input  logic       frame_ready,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    input  logic       xmit_rdy,
    output logic       fifo_rd_en,
    output logic       xmit_valid,
    output logic [7:0] xmit_data,
    output logic       busy,
    output logic       tx_done,
    output logic [7:0] defer_cnt,
    output logic [2:0] STATE
);

    localparam int unsigned TW = $clog2(DIFS_TICKS + 1);
    localparam int unsigned SW = $clog2(SLOT_TICKS + 1);
    localparam int unsigned PW = $clog2(PREAMBLE_BYTES + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(DIFS_TICKS - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_TICKS - 1);
    localparam logic [SW-1:0] SLOT_ONE  = SW'(1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(PREAMBLE_BYTES - 1);
    localparam logic [PW-1:0] PRE_ONE   = PW'(1);

    state_t        state_r, state_s;
    logic [TW-1:0] tick_cnt_r, tick_cnt_s;
    logic [SW-1:0] slot_cnt_r, slot_cnt_s;
    logic [PW-1:0] pre_cnt_r, pre_cnt_s;
    logic [7:0]    backoff_r, backoff_s;
    logic          held_r, held_s;
    logic [2:0]    cw_exp_r, cw_exp_s;
    logic [7:0]    defer_cnt_r;
    logic          carrier_seen_r, carrier_seen_s;
    logic          defer_inc_s;
    logic [7:0]    lfsr_s;
    logic [7:0]    cw_mask_s;
    logic [7:0]    draw_s;
    logic          valid_s;
    logic [7:0]    data_s;
    logic          xfer_s;

    lfsr8 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .value (lfsr_s)
    );

    assign cw_mask_s = cw_mask_of(cw_exp_r);
    assign draw_s    = held_r ? backoff_r : (lfsr_s & cw_mask_s);

    // Byte presented to the transmitter; nothing is offered while reset is low so no pop can occur.
    always_comb begin
        valid_s = 1'b0;
        data_s  = 8'h00;
        case (state_r)
            ST_PREAMBLE: begin
                valid_s = 1'b1;
                data_s  = PREAMBLE_BYTE;
            end
            ST_SFD: begin
                valid_s = 1'b1;
                data_s  = SFD_BYTE;
            end
            ST_DATA: begin
                valid_s = !fifo_empty;
                data_s  = fifo_empty ? 8'h00 : fifo_data;
            end
            default: begin
                valid_s = 1'b0;
                data_s  = 8'h00;
            end
        endcase
        if (!rst) begin
            valid_s = 1'b0;
            data_s  = 8'h00;
        end else begin
            valid_s = valid_s;
        end
    end

    assign xfer_s     = valid_s & xmit_rdy;
    assign xmit_valid = valid_s;
    assign xmit_data  = data_s;
    assign fifo_rd_en = xfer_s & (state_r == ST_DATA);
    assign busy       = (state_r != ST_IDLE);
    assign tx_done    = (state_r == ST_DONE);
    assign STATE      = state_r;
    assign defer_cnt  = defer_cnt_r;

    // Next-state logic for the controller and its counters.
    always_comb begin
        state_s        = state_r;
        tick_cnt_s     = tick_cnt_r;
        slot_cnt_s     = slot_cnt_r;
        pre_cnt_s      = pre_cnt_r;
        backoff_s      = backoff_r;
        held_s         = held_r;
        cw_exp_s       = cw_exp_r;
        carrier_seen_s = 1'b0;
        defer_inc_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                tick_cnt_s = '0;
                slot_cnt_s = '0;
                pre_cnt_s  = '0;
                if (frame_ready) begin
                    state_s = ST_DIFS;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DIFS: begin
                slot_cnt_s = '0;
                if (cardet) begin
                    // One deferral per busy episode, not per busy cycle.
                    tick_cnt_s     = '0;
                    carrier_seen_s = 1'b1;
                    defer_inc_s    = !carrier_seen_r;
                end else if (mx_br_en) begin
                    if (tick_cnt_r == TICK_LAST) begin
                        tick_cnt_s = '0;
                        backoff_s  = draw_s;
                        held_s     = 1'b1;
                        state_s    = (draw_s == 8'd0) ? ST_PREAMBLE : ST_BACKOFF;
                    end else begin
                        tick_cnt_s = tick_cnt_r + TICK_ONE;
                    end
                end else begin
                    tick_cnt_s = tick_cnt_r;
                end
            end
            ST_BACKOFF: begin
                if (cardet) begin
                    // Abort keeps the remaining backoff; the partial slot is discarded.
                    state_s        = ST_DIFS;
                    tick_cnt_s     = '0;
                    slot_cnt_s     = '0;
                    carrier_seen_s = 1'b1;
                    defer_inc_s    = 1'b1;
                    cw_exp_s       = (cw_exp_r == CW_EXP_MAX) ? CW_EXP_MAX : (cw_exp_r + 3'd1);
                end else if (backoff_r == 8'd0) begin
                    state_s = ST_PREAMBLE;
                end else if (mx_br_en) begin
                    if (slot_cnt_r == SLOT_LAST) begin
                        slot_cnt_s = '0;
                        backoff_s  = backoff_r - 8'd1;
                        state_s    = (backoff_r == 8'd1) ? ST_PREAMBLE : ST_BACKOFF;
                    end else begin
                        slot_cnt_s = slot_cnt_r + SLOT_ONE;
                    end
                end else begin
                    slot_cnt_s = slot_cnt_r;
                end
            end
            ST_PREAMBLE: begin
                if (xfer_s) begin
                    if (pre_cnt_r == PRE_LAST) begin
                        pre_cnt_s = '0;
                        state_s   = ST_SFD;
                    end else begin
                        pre_cnt_s = pre_cnt_r + PRE_ONE;
                    end
                end else begin
                    pre_cnt_s = pre_cnt_r;
                end
            end
            ST_SFD: begin
                if (xfer_s) begin
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_SFD;
                end
            end
            ST_DATA: begin
                if (fifo_empty) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_DONE: begin
                held_s    = 1'b0;
                backoff_s = 8'd0;
                cw_exp_s  = CW_EXP_MIN;
                state_s   = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Controller state and counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r        <= ST_IDLE;
            tick_cnt_r     <= '0;
            slot_cnt_r     <= '0;
            pre_cnt_r      <= '0;
            backoff_r      <= 8'd0;
            held_r         <= 1'b0;
            cw_exp_r       <= CW_EXP_MIN;
            defer_cnt_r    <= 8'd0;
            carrier_seen_r <= 1'b0;
        end else begin
            state_r        <= state_s;
            tick_cnt_r     <= tick_cnt_s;
            slot_cnt_r     <= slot_cnt_s;
            pre_cnt_r      <= pre_cnt_s;
            backoff_r      <= backoff_s;
            held_r         <= held_s;
            cw_exp_r       <= cw_exp_s;
            carrier_seen_r <= carrier_seen_s;
            if (defer_inc_s && (defer_cnt_r != 8'hFF)) begin
                defer_cnt_r <= defer_cnt_r + 8'd1;
            end else begin
                defer_cnt_r <= defer_cnt_r;
            end
        end
    end

endmodule
